commu_pack: RTL and testbench

//  Next-generation communication capture block. Accepts DATA_W-bit beats qualified by wr_en,

---
 rtl/commu_pkg.sv | 15 +
 rtl/commu_pack_if.sv | 32 +++
 rtl/commu_fifo.sv | 64 ++++++
 rtl/commu_pack.sv | 91 +++++++++
 tb/tb_commu_pack.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/commu_pkg.sv
// Shared constants and the packed word type of the capture path.
// Also used by the modulator datapath, so the word layout must stay stable.
package commu_pkg;

  localparam int COMMU_DATA_W = 8;
  localparam int COMMU_BEATS  = 4;
  localparam int COMMU_DEPTH  = 4;
  localparam int COMMU_CNT_W  = $clog2(COMMU_BEATS + 1);

  typedef struct packed {
    logic [COMMU_CNT_W-1:0]              cnt;
    logic [COMMU_DATA_W*COMMU_BEATS-1:0] data;
  } commu_word_t;

endpackage

// File: rtl/commu_pack_if.sv
// Beat input, packed-word output and status bundle of commu_pack.
// slave is the packer's view, master is the driver/consumer view.
interface commu_pack_if
  import commu_pkg::*;
#(
  parameter int DATA_W = COMMU_DATA_W,
  parameter int BEATS  = COMMU_BEATS,
  parameter int DEPTH  = COMMU_DEPTH
);

  logic                         wr_en;
  logic [DATA_W-1:0]            ext_data;
  logic                         last;
  logic                         ready;
  logic                         clr_ovf;
  logic [DATA_W*BEATS-1:0]      cov_data;
  logic [$clog2(BEATS+1)-1:0]   cov_cnt;
  logic                         valid;
  logic                         overflow;
  logic [$clog2(DEPTH+1)-1:0]   level;

  modport master (
    output wr_en, ext_data, last, ready, clr_ovf,
    input  cov_data, cov_cnt, valid, overflow, level
  );

  modport slave (
    input  wr_en, ext_data, last, ready, clr_ovf,
    output cov_data, cov_cnt, valid, overflow, level
  );

endinterface

// File: rtl/commu_fifo.sv
// Synchronous word FIFO; head is combinational from storage, no bypass.
// A push while full is accepted only when a pop happens on the same edge.
module commu_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  assign empty   = (level_q == '0);
  assign full    = (level_q == LW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is readable.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign level = level_q;

endmodule

// File: rtl/commu_pack.sv
// Packs BEATS input beats (or a partial frame ended by last) into one word and queues it.
// Head word appears the cycle after completion; full FIFO without a pop drops the word (sticky overflow).
module commu_pack
  import commu_pkg::*;
#(
  parameter int DATA_W    = COMMU_DATA_W,
  parameter int BEATS     = COMMU_BEATS,
  parameter int DEPTH     = COMMU_DEPTH,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  commu_pack_if.slave  bus
);

  localparam int WW = DATA_W * BEATS;
  localparam int IW = $clog2(BEATS);
  localparam int CW = $clog2(BEATS + 1);

  logic [IW-1:0]    idx_q, idx_d, slot;
  logic [WW-1:0]    pack_q, pack_d, word_asm;
  logic             ovf_q, ovf_d;
  logic             complete, pop, drop;
  logic [CW-1:0]    cnt;
  logic [CW+WW-1:0] fifo_dout;
  logic             fifo_empty, fifo_full;

  assign slot = LSB_FIRST ? idx_q : (IW'(BEATS - 1) - idx_q);

  always_comb begin
    word_asm = pack_q;
    for (int b = 0; b < BEATS; b++) begin
      if (IW'(b) == slot) word_asm[b*DATA_W +: DATA_W] = bus.ext_data;
    end
  end

  assign complete = bus.wr_en && ((idx_q == IW'(BEATS - 1)) || bus.last);
  assign cnt      = CW'(idx_q) + CW'(1);
  assign pop      = bus.ready && !fifo_empty;
  assign drop     = complete && fifo_full && !pop;

  always_comb begin
    idx_d  = idx_q;
    pack_d = pack_q;
    if (bus.wr_en) begin
      if (complete) begin
        idx_d  = '0;
        pack_d = '0;
      end else begin
        idx_d  = idx_q + IW'(1);
        pack_d = word_asm;
      end
    end
  end

  // A fresh drop outranks a clear in the same cycle.
  assign ovf_d = drop || (ovf_q && !bus.clr_ovf);

  always_ff @(posedge clk) begin
    if (!rst) begin
      idx_q  <= '0;
      pack_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      pack_q <= pack_d;
      ovf_q  <= ovf_d;
    end
  end

  commu_fifo #(
    .WIDTH (CW + WW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (complete),
    .din   ({cnt, word_asm}),
    .pop   (bus.ready),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (bus.level)
  );

  assign bus.valid    = !fifo_empty;
  assign bus.cov_data = fifo_empty ? '0 : fifo_dout[WW-1:0];
  assign bus.cov_cnt  = fifo_empty ? '0 : fifo_dout[CW+WW-1:WW];
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_commu_pack.sv
// Scoreboard bench for commu_pack: LSB-first instance with a reference queue,
// plus an MSB-first instance for ordering and overflow set-wins checks.
module tb_commu_pack;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  commu_pack_if #(.DATA_W(8), .BEATS(4), .DEPTH(4)) a_if ();
  commu_pack_if #(.DATA_W(8), .BEATS(4), .DEPTH(4)) b_if ();

  commu_pack #(.DATA_W(8), .BEATS(4), .DEPTH(4), .LSB_FIRST(1'b1)) u_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if)
  );

  commu_pack #(.DATA_W(8), .BEATS(4), .DEPTH(4), .LSB_FIRST(1'b0)) u_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if)
  );

  int n_chk = 0;
  int n_err = 0;

  logic [34:0] exp_q[$];
  int          idx_m = 0;
  logic [31:0] pack_m = '0;
  bit          ovf_m = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock on DUT A; inputs applied at the falling edge, model updated, outputs checked next falling edge.
  task automatic cyc(input bit we, input logic [7:0] d, input bit lst, input bit rdy, input bit clr);
    bit          pop, full, drop;
    logic [34:0] w;
    a_if.wr_en = we; a_if.ext_data = d; a_if.last = lst; a_if.ready = rdy; a_if.clr_ovf = clr;
    full = (exp_q.size() == 4);
    pop  = rdy && (exp_q.size() != 0);
    drop = 1'b0;
    if (pop) begin
      w = exp_q.pop_front();
      chk("pop_data", a_if.cov_data, w[31:0]);
      chk("pop_cnt",  a_if.cov_cnt,  w[34:32]);
    end
    if (we) begin
      pack_m[idx_m*8 +: 8] = d;
      if (idx_m == 3 || lst) begin
        w = {3'(idx_m + 1), pack_m};
        if (!full || pop) exp_q.push_back(w);
        else drop = 1'b1;
        idx_m  = 0;
        pack_m = '0;
      end else begin
        idx_m++;
      end
    end
    ovf_m = drop ? 1'b1 : (clr ? 1'b0 : ovf_m);
    @(posedge clk);
    @(negedge clk);
    chk("level", a_if.level, exp_q.size());
    chk("valid", a_if.valid, exp_q.size() != 0);
    chk("ovf",   a_if.overflow, ovf_m);
    if (exp_q.size() == 0) begin
      chk("empty_data", a_if.cov_data, 0);
      chk("empty_cnt",  a_if.cov_cnt,  0);
    end
  endtask

  task automatic word(input logic [31:0] v, input bit rdy);
    for (int i = 0; i < 4; i++) cyc(1'b1, v[i*8 +: 8], 1'b0, rdy, 1'b0);
  endtask

  task automatic bcyc(input bit we, input logic [7:0] d, input bit rdy, input bit clr);
    b_if.wr_en = we; b_if.ext_data = d; b_if.last = 1'b0; b_if.ready = rdy; b_if.clr_ovf = clr;
    @(posedge clk);
    @(negedge clk);
    b_if.wr_en = 1'b0; b_if.ready = 1'b0; b_if.clr_ovf = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    a_if.wr_en = 0; a_if.ext_data = 0; a_if.last = 0; a_if.ready = 0; a_if.clr_ovf = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    idx_m = 0; pack_m = '0; ovf_m = 1'b0;
    chk("rst_valid", a_if.valid, 0);
    chk("rst_data",  a_if.cov_data, 0);
    chk("rst_cnt",   a_if.cov_cnt, 0);
    chk("rst_ovf",   a_if.overflow, 0);
    chk("rst_level", a_if.level, 0);
  endtask

  initial begin
    b_if.wr_en = 0; b_if.ext_data = 0; b_if.last = 0; b_if.ready = 0; b_if.clr_ovf = 0;
    @(negedge clk);
    do_reset();
    chk("rst_b_valid", b_if.valid, 0);
    chk("rst_b_level", b_if.level, 0);

    // Full word, no consumer
    word(32'h44332211, 1'b0);
    chk("t1_data",  a_if.cov_data, 32'h44332211);
    chk("t1_cnt",   a_if.cov_cnt, 4);
    chk("t1_level", a_if.level, 1);

    // Partial frame flushed by last, then a fresh word
    cyc(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'hBB, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("t2_data", a_if.cov_data, 32'h0000BBAA);
    chk("t2_cnt",  a_if.cov_cnt, 2);
    cyc(1'b1, 8'hCC, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 8'hDD, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    chk("t2_fresh", a_if.cov_data, 32'hFFEEDDCC);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Overflow: fifth word dropped, drain preserves order
    for (int i = 1; i <= 5; i++) word(32'h01010101 * i, 1'b0);
    chk("t3_level", a_if.level, 4);
    chk("t3_ovf",   a_if.overflow, 1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("t3_drained", a_if.valid, 0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("t3_clr", a_if.overflow, 0);

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < 4; i++) word(32'hA0B0C0D0 + i, 1'b0);
    cyc(1'b1, 8'h51, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h52, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h53, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h54, 1'b0, 1'b1, 1'b0);
    chk("t4_level", a_if.level, 4);
    chk("t4_ovf",   a_if.overflow, 0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Reset mid-frame with buffered words
    word(32'h12345678, 1'b0);
    word(32'h9ABCDEF0, 1'b0);
    cyc(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h88, 1'b0, 1'b0, 1'b0);
    do_reset();
    word(32'hDEADBEEF, 1'b0);
    chk("t5_data", a_if.cov_data, 32'hDEADBEEF);
    chk("t5_cnt",  a_if.cov_cnt, 4);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // MSB-first ordering, then clear coinciding with a drop
    bcyc(1'b1, 8'h11, 1'b0, 1'b0);
    bcyc(1'b1, 8'h22, 1'b0, 1'b0);
    bcyc(1'b1, 8'h33, 1'b0, 1'b0);
    bcyc(1'b1, 8'h44, 1'b0, 1'b0);
    chk("t6_data", b_if.cov_data, 32'h11223344);
    chk("t6_cnt",  b_if.cov_cnt, 4);
    for (int i = 0; i < 16; i++) bcyc(1'b1, 8'(i), 1'b0, 1'b0);
    chk("t6_level", b_if.level, 4);
    chk("t6_ovf",   b_if.overflow, 1);
    bcyc(1'b1, 8'h01, 1'b0, 1'b0);
    bcyc(1'b1, 8'h02, 1'b0, 1'b0);
    bcyc(1'b1, 8'h03, 1'b0, 1'b0);
    bcyc(1'b1, 8'h04, 1'b0, 1'b1);
    chk("t6_set_wins", b_if.overflow, 1);
    bcyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("t6_clr", b_if.overflow, 0);
    chk("t6_head", b_if.cov_data, 32'h11223344);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
